// File: rtl/parity_frame_ctrl_pkg.sv
// Shared types, constants and helpers for the parity frame controller.
package parity_pkg;

  // Handshake / sequencing states of the controller.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Encoding of the serial parity tracker.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Bit counter must hold the value DATA_W (index of the parity bit).
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  // Final tracker state matches the expected parity sense.
  function automatic logic parity_match(input logic par_state, input logic odd_mode);
    return par_state == (odd_mode ? PAR_ODD : PAR_EVEN);
  endfunction

endpackage

// File: rtl/parity_frame_ctrl_seq.sv
// Two-state Even/Odd serial parity tracker; clr returns it to Even.
module parity_seq
  import parity_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic par_state
);

  // Toggle on every enabled 1 bit; a synchronous clear wins over enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_state <= PAR_EVEN;
    end else if (clr) begin
      par_state <= PAR_EVEN;
    end else if (en && bit_in) begin
      par_state <= ~par_state;
    end
  end

endmodule

// File: rtl/parity_frame_ctrl.sv
// Parity frame controller: accepts a word plus parity bit, streams it LSB
// first through one shared serial tracker, reports pass/fail and keeps a
// saturating count of failed words.
module parity_frame_ctrl
  import parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_par,
  input  logic                 odd_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_ok,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(DATA_W);

  state_t               state_r;
  state_t               next_s;
  logic [DATA_W:0]      shreg_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 mode_r;
  logic                 ok_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;

  logic accept_s;
  logic shift_s;
  logic last_s;
  logic report_hs_s;
  logic par_state_s;
  logic final_par_s;
  logic ok_s;

  assign accept_s    = (state_r == IDLE) && in_valid;
  assign shift_s     = (state_r == SHIFT);
  assign last_s      = shift_s && (cnt_r == CNT_W'(DATA_W));
  assign report_hs_s = (state_r == REPORT) && out_ready;

  // The tracker absorbs the last bit on the same edge that enters REPORT,
  // so the verdict is formed from the tracker's next value.
  assign final_par_s = par_state_s ^ shreg_r[0];
  assign ok_s        = parity_match(final_par_s, mode_r);

  parity_seq u_seq (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept_s),
    .en        (shift_s),
    .bit_in    (shreg_r[0]),
    .par_state (par_state_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic: accept in IDLE, count bits in SHIFT, wait for consumer in REPORT.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          next_s = SHIFT;
        end else begin
          next_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          next_s = REPORT;
        end else begin
          next_s = SHIFT;
        end
      end
      REPORT: begin
        if (out_ready) begin
          next_s = IDLE;
        end else begin
          next_s = REPORT;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // Capture the word at accept, then shift it right one bit per SHIFT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_r <= {(DATA_W + 1){1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      mode_r  <= 1'b0;
    end else if (accept_s) begin
      shreg_r <= {in_par, in_data};
      cnt_r   <= {CNT_W{1'b0}};
      mode_r  <= odd_mode;
    end else if (shift_s) begin
      shreg_r <= {1'b0, shreg_r[DATA_W:1]};
      if (!last_s) begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end
    end
  end

  // Verdict register: set when entering REPORT, cleared once the result is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ok_r <= 1'b0;
    end else if (last_s) begin
      ok_r <= ok_s;
    end else if (report_hs_s) begin
      ok_r <= 1'b0;
    end
  end

  // Saturating failure counter; a clear in the same cycle drops the increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_r <= {ERR_CNT_W{1'b0}};
    end else if (err_clr) begin
      err_cnt_r <= {ERR_CNT_W{1'b0}};
    end else if (last_s && !ok_s && !(&err_cnt_r)) begin
      err_cnt_r <= err_cnt_r + ERR_CNT_W'(1'b1);
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == REPORT);
  assign busy      = (state_r != IDLE);
  assign out_ok    = ok_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Self-checking bench for parity_frame_ctrl: a transaction-level timeline
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_parity_frame_ctrl;

  localparam int DATA_W    = 8;
  localparam int ERR_CNT_W = 8;
  localparam int ERR_MAX   = 255;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data = 8'h00;
  logic                 in_par = 1'b0;
  logic                 odd_mode = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 out_ok;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 err_clr = 1'b0;
  logic                 busy;

  int n_tests = 0;
  int n_fail  = 0;

  parity_frame_ctrl #(.DATA_W(DATA_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_par    (in_par),
    .odd_mode  (odd_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ok    (out_ok),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Parity verdict from the word's definition: total ones of data+parity.
  function automatic bit exp_ok(input logic [DATA_W-1:0] d, input logic p, input logic m);
    return ((($countones(d) + int'(p)) % 2) == 1) == m;
  endfunction

  // Timeline model: idle / word in flight with cycles left / result pending.
  bit m_ready = 1'b1;
  bit m_valid = 1'b0;
  bit m_ok    = 1'b0;
  bit m_exp   = 1'b0;
  int m_left  = 0;
  int m_err   = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_ok    <= 1'b0;
      m_left  <= 0;
      m_err   <= 0;
    end else begin
      if (m_ready && in_valid) begin
        m_ready <= 1'b0;
        m_left  <= DATA_W + 1;
        m_exp   <= exp_ok(in_data, in_par, odd_mode);
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_valid <= 1'b1;
          m_ok    <= m_exp;
        end
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
        m_ready <= 1'b1;
      end
      if (err_clr) begin
        m_err <= 0;
      end else if (m_left == 1 && !m_exp && m_err < ERR_MAX) begin
        m_err <= m_err + 1;
      end
    end
  end

  // Compare DUT against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst) begin
      check("in_ready", int'(in_ready), int'(m_ready));
      check("busy", int'(busy), int'(!m_ready));
      check("out_valid", int'(out_valid), int'(m_valid));
      check("err_cnt", int'(err_cnt), m_err);
      if (m_valid) check("out_ok", int'(out_ok), int'(m_ok));
    end
  end

  // Offer a word (called at a falling edge); returns at the first falling edge after accept.
  task automatic send(input logic [DATA_W-1:0] d, input logic p, input logic m);
    in_data = d; in_par = p; odd_mode = m; in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    if (!in_ready) check("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for out_valid; lat counts falling edges from the one after accept (=1).
  task automatic wait_result(output int lat, output logic ok);
    lat = 1;
    for (int i = 0; i < 60 && !out_valid; i++) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("result_timeout", 0, 1);
    ok = out_ok;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && !in_ready; i++) @(negedge clk);
    if (!in_ready) check("idle_timeout", 0, 1);
  endtask

  int   lat;
  logic ok;
  int   n_acc, hs_at, acc2_at, seen_valid;
  logic first_ok;

  initial begin
    // Reset values.
    #3;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_ok", int'(out_ok), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 0xA5 has four ones, parity 0, even -> pass, result 10 cycles on.
    send(8'hA5, 1'b0, 1'b0);
    wait_result(lat, ok);
    check("a5_latency", lat, 10);
    check("a5_ok", int'(ok), 1);
    check("a5_err", int'(err_cnt), 0);
    @(negedge clk);

    // 0x01 even parity 0 -> fail; same word under odd mode -> pass.
    send(8'h01, 1'b0, 1'b0);
    wait_result(lat, ok);
    check("01_even_ok", int'(ok), 0);
    check("01_even_err", int'(err_cnt), 1);
    @(negedge clk);
    send(8'h01, 1'b0, 1'b1);
    wait_result(lat, ok);
    check("01_odd_ok", int'(ok), 1);
    check("01_odd_err", int'(err_cnt), 1);
    @(negedge clk);

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    send(8'hA5, 1'b0, 1'b0);
    wait_result(lat, ok);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_ok", int'(out_ok), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_busy", int'(busy), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_release_out_valid", int'(out_valid), 0);

    // Reset in the third SHIFT cycle abandons the word and clears err_cnt.
    send(8'h01, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_ok", int'(out_ok), 0);
    check("mid_rst_err_cnt", int'(err_cnt), 0);
    check("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    seen_valid = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("mid_rst_no_result", seen_valid, 0);
    send(8'hFF, 1'b0, 1'b0);
    wait_result(lat, ok);
    check("ff_ok", int'(ok), 1);
    check("ff_err", int'(err_cnt), 0);
    @(negedge clk);

    // 260 failing words saturate the counter.
    for (int w = 0; w < 260; w++) begin
      send(8'h01, 1'b0, 1'b0);
      wait_result(lat, ok);
      @(negedge clk);
    end
    check("sat_err", int'(err_cnt), 255);

    // Clear coinciding with the next failure edge wins.
    send(8'h01, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_out_valid", int'(out_valid), 1);
    check("clr_out_ok", int'(out_ok), 0);
    check("clr_err", int'(err_cnt), 0);
    @(negedge clk);

    // in_valid held high, bus scrambled while busy.
    wait_idle();
    in_valid = 1'b1;
    n_acc = 0; hs_at = -1; acc2_at = -1; first_ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid && out_ready && hs_at < 0) begin
        hs_at = i;
        first_ok = out_ok;
      end
      if (in_ready) begin
        n_acc++;
        if (n_acc == 2) acc2_at = i;
        in_data = 8'h3C; odd_mode = 1'b0;
        in_par = (n_acc == 2) ? 1'b1 : 1'b0;
      end else begin
        in_data  = 8'($urandom);
        in_par   = 1'($urandom);
        odd_mode = 1'($urandom);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("hold_first_ok", int'(first_ok), 1);
    check("hold_hs_at", hs_at, 10);
    check("hold_acc2_at", acc2_at, 11);
    wait_idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
